wb_writeback_arbiter: RTL

- Writer-side front end of the 8x16 register file's single write port.
- Merges two writeback sources into one registered write: the single-cycle ALU/LI result path and the multi-cycle data-memory load-return path.
- Buffers load returns in a small FIFO and bounds load starvation.
- Keeps a per-register pending-load scoreboard that decode uses to stall on load-use hazards.

---
 rtl/wb_writeback_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/wb_writeback_arbiter.sv
// Generic in-order FIFO for single-clock buffering with registered storage.
// Latency: a push is visible at pop_dat one cycle later; a pop is a read of the head.
// Backpressure: full is derived from occupancy only, so a same-cycle pop never frees a slot early.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_vld,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_vld && !pop_vld) begin
                cnt <= cnt + CNT_ONE;
            end else if (!push_vld && pop_vld) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign count   = cnt;
    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);

endmodule

// Merges ALU results and buffered load returns onto the single register-file write port.
// Latency: ALU accept -> write next edge; load push -> earliest write two edges later.
// Backpressure: ld_ready drops when the load FIFO is full; alu_ready drops when a load is forced.
module wb_writeback_arbiter #(
    parameter int LD_DEPTH     = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [2:0]                  alu_wa,
    input  logic [15:0]                 alu_wd,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [2:0]                  ld_wa,
    input  logic [15:0]                 ld_wd,
    input  logic                        issue_valid,
    input  logic [2:0]                  issue_wa,
    output logic [7:0]                  busy,
    output logic                        we,
    output logic [2:0]                  wa,
    output logic [15:0]                 wd,
    output logic [$clog2(LD_DEPTH):0]   fifo_count
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    typedef struct packed {
        logic [2:0]  wa;
        logic [15:0] wd;
    } ld_req_t;

    ld_req_t        push_req;
    ld_req_t        head_req;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           alu_gnt;
    logic           ld_gnt;
    logic [SW-1:0]  starve_cnt;
    logic [SW-1:0]  starve_next;
    logic [7:1]     busy_q;
    logic [7:1]     busy_next;
    logic           we_next;

    assign push_req = {ld_wa, ld_wd};
    assign ld_ready = !fifo_full;
    assign push     = ld_valid && ld_ready;

    wb_fifo #(
        .W     ($bits(ld_req_t)),
        .DEPTH (LD_DEPTH)
    ) u_ld_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push),
        .push_dat (push_req),
        .pop_vld  (ld_gnt),
        .pop_dat  (head_req),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Grant selection: ALU wins until it has starved a waiting load STARVE_LIMIT times.
    always_comb begin
        alu_gnt     = 1'b0;
        ld_gnt      = 1'b0;
        starve_next = starve_cnt;
        if (fifo_empty) begin
            alu_gnt     = alu_valid;
            starve_next = '0;
        end else if (alu_valid && (starve_cnt < STARVE_MAX)) begin
            alu_gnt     = 1'b1;
            starve_next = starve_cnt + STARVE_ONE;
        end else begin
            ld_gnt      = 1'b1;
            starve_next = '0;
        end
    end

    assign alu_ready = alu_gnt;

    // Writes to R0 are consumed but never enabled on the register file.
    assign we_next = (alu_gnt && (alu_wa != 3'd0)) || (ld_gnt && (head_req.wa != 3'd0));

    // Pending-load bits: a popped load clears its bit, a new issue to the same register wins.
    always_comb begin
        busy_next = busy_q;
        for (int i = 1; i < 8; i++) begin
            if (ld_gnt && (head_req.wa == 3'(i))) begin
                busy_next[i] = 1'b0;
            end
            if (issue_valid && (issue_wa == 3'(i))) begin
                busy_next[i] = 1'b1;
            end
        end
    end

    // Starvation counter and scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            busy_q     <= '0;
        end else begin
            starve_cnt <= starve_next;
            busy_q     <= busy_next;
        end
    end

    // Registered write port; address/data hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we <= 1'b0;
            wa <= '0;
            wd <= '0;
        end else begin
            we <= we_next;
            if (alu_gnt) begin
                wa <= alu_wa;
                wd <= alu_wd;
            end else if (ld_gnt) begin
                wa <= head_req.wa;
                wd <= head_req.wd;
            end
        end
    end

    assign busy = {busy_q, 1'b0};

endmodule
